// File: rtl/data_format_pkg.sv
// Shared sizing helpers and slice-order selection for the data format gearbox.
package data_format_pkg;

  // Number of output slices per input word; zero marks an illegal width pair.
  function automatic int unsigned calc_ratio(input int unsigned di_w, input int unsigned do_w);
    return (do_w == 0) ? 0 : di_w / do_w;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned calc_iw(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Maps the emission index k to the physical slice position inside the word.
  function automatic int unsigned slice_sel(input int unsigned k, input int unsigned ratio,
                                            input bit msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/data_fifo_sync.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
module data_fifo_sync
  import data_format_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic [calc_cw(DEPTH)-1:0] count,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = calc_cw(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/data_format_gearbox.sv
// Wide-to-narrow gearbox: buffers input words and emits them as DO_WIDTH slices.
module data_format_gearbox
  import data_format_pkg::*;
#(
  parameter int unsigned DI_WIDTH  = 64,
  parameter int unsigned DO_WIDTH  = 32,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DI_WIDTH-1:0]       data_in,
  input  logic                      din_vd,
  output logic                      din_rdy,
  output logic [DO_WIDTH-1:0]       data_out,
  output logic                      dout_vd,
  input  logic                      dout_rdy,
  output logic [calc_cw(DEPTH)-1:0] level,
  output logic                      ovf_err
);

  localparam int unsigned RATIO = calc_ratio(DI_WIDTH, DO_WIDTH);
  localparam int unsigned CW    = calc_cw(DEPTH);
  localparam int unsigned IW    = calc_iw(RATIO);
  localparam int unsigned DO_NZ = (DO_WIDTH == 0) ? 1 : DO_WIDTH;

  if (DO_WIDTH == 0 || DI_WIDTH == 0 || (DI_WIDTH % DO_NZ) != 0) begin : g_bad_width
    $error("data_format_gearbox: DI_WIDTH must be a nonzero multiple of DO_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_format_gearbox: DEPTH must be a power of two, at least 2");
  end

  logic [DI_WIDTH-1:0]           head;
  logic                          fifo_empty, fifo_full;
  logic                          push, pop, xfer, last;
  logic [DI_WIDTH-1:0]           word_q, word_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          loaded_q, loaded_d;
  logic [DO_WIDTH-1:0]           data_out_q, data_out_d;
  logic                          ovf_q, ovf_d;
  logic [IW-1:0]                 sel;
  logic [RATIO-1:0][DO_WIDTH-1:0] word_slices;

  assign din_rdy  = ~fifo_full;
  assign push     = din_vd & din_rdy;
  assign dout_vd  = loaded_q;
  assign data_out = data_out_q;
  assign ovf_err  = ovf_q;

  data_fifo_sync #(
    .WIDTH (DI_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (head),
    .count   (level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Output stage: refill on the final slice so back-to-back words leave no bubble.
  always_comb begin
    xfer     = loaded_q & dout_rdy;
    last     = (idx_q == IW'(RATIO - 1));
    pop      = ~fifo_empty & (~loaded_q | (xfer & last));
    word_d   = word_q;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    if (pop) begin
      word_d   = head;
      idx_d    = '0;
      loaded_d = 1'b1;
    end else if (xfer) begin
      if (last) loaded_d = 1'b0;
      else      idx_d    = idx_q + IW'(1);
    end
    word_slices = word_d;
    sel         = IW'(slice_sel(32'(idx_d), RATIO, MSB_FIRST));
    data_out_d  = word_slices[sel];
    ovf_d       = ovf_q | (din_vd & ~din_rdy);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q     <= '0;
      idx_q      <= '0;
      loaded_q   <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      word_q     <= word_d;
      idx_q      <= idx_d;
      loaded_q   <= loaded_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_data_format_gearbox.sv
// Scoreboard bench: three gearbox instances (LSB-first, MSB-first, 128->32) driven by directed vectors.
`timescale 1ns/1ps
module tb_data_format_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        rst_a, rst_b, rst_c;
  logic [63:0] din_a, din_b;
  logic [127:0] din_c;
  logic        vd_a, vd_b, vd_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic [31:0] dout_a, dout_b, dout_c;
  logic        dvd_a, dvd_b, dvd_c;
  logic        drdy_a, drdy_b, drdy_c;
  logic [2:0]  lvl_a, lvl_b, lvl_c;
  logic        ovf_a, ovf_b, ovf_c;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  logic [63:0] w3 [6];
  logic [63:0] t5 [4];

  data_format_gearbox #(.DI_WIDTH(64), .DO_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset_n(rst_a), .data_in(din_a), .din_vd(vd_a), .din_rdy(rdy_a),
    .data_out(dout_a), .dout_vd(dvd_a), .dout_rdy(drdy_a), .level(lvl_a), .ovf_err(ovf_a));

  data_format_gearbox #(.DI_WIDTH(64), .DO_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset_n(rst_b), .data_in(din_b), .din_vd(vd_b), .din_rdy(rdy_b),
    .data_out(dout_b), .dout_vd(dvd_b), .dout_rdy(drdy_b), .level(lvl_b), .ovf_err(ovf_b));

  data_format_gearbox #(.DI_WIDTH(128), .DO_WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .reset_n(rst_c), .data_in(din_c), .din_vd(vd_c), .din_rdy(rdy_c),
    .data_out(dout_c), .dout_vd(dvd_c), .dout_rdy(drdy_c), .level(lvl_c), .ovf_err(ovf_c));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare whenever a slice is transferred on the next edge.
  always @(negedge clk) begin
    if (dvd_a && drdy_a) begin
      if (qa.size() == 0) begin
        total_cnt++;
        $display("FAIL a_unexpected: got slice %08h, required none", dout_a);
      end else chk("a_slice", 128'(dout_a), 128'(qa.pop_front()));
    end
    if (dvd_b && drdy_b) begin
      if (qb.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected: got slice %08h, required none", dout_b);
      end else chk("b_slice", 128'(dout_b), 128'(qb.pop_front()));
    end
    if (dvd_c && drdy_c) begin
      if (qc.size() == 0) begin
        total_cnt++;
        $display("FAIL c_unexpected: got slice %08h, required none", dout_c);
      end else chk("c_slice", 128'(dout_c), 128'(qc.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    w3[0] = 64'h0000_0101_0000_0100; w3[1] = 64'h0000_0201_0000_0200;
    w3[2] = 64'h0000_0301_0000_0300; w3[3] = 64'h0000_0401_0000_0400;
    w3[4] = 64'h0000_0501_0000_0500; w3[5] = 64'h0000_0601_0000_0600;
    t5[0] = 64'h0B0B_0001_0A0A_0001; t5[1] = 64'h0B0B_0002_0A0A_0002;
    t5[2] = 64'h0B0B_0003_0A0A_0003; t5[3] = 64'h0B0B_0004_0A0A_0004;

    rst_a = 0; rst_b = 0; rst_c = 0;
    vd_a = 0; vd_b = 0; vd_c = 0;
    din_a = '0; din_b = '0; din_c = '0;
    drdy_a = 1; drdy_b = 1; drdy_c = 0;
    repeat (2) step();
    rst_a = 1; rst_b = 1; rst_c = 1;
    @(negedge clk);
    chk("rst_dout_vd", 128'(dvd_a), 128'(0));
    chk("rst_level", 128'(lvl_a), 128'(0));
    chk("rst_ovf", 128'(ovf_a), 128'(0));
    chk("rst_din_rdy", 128'(rdy_a), 128'(1));
    chk("rst_data_out", 128'(dout_a), 128'(0));

    // Single word, both slice orders, two-edge latency.
    step();
    vd_a = 1; vd_b = 1;
    din_a = 64'h1111_2222_3333_4444; din_b = 64'h1111_2222_3333_4444;
    qa.push_back(32'h3333_4444); qa.push_back(32'h1111_2222);
    qb.push_back(32'h1111_2222); qb.push_back(32'h3333_4444);
    step();
    vd_a = 0; vd_b = 0;
    @(negedge clk);
    chk("a_lat_edge1", 128'(dvd_a), 128'(0));
    chk("b_lat_edge1", 128'(dvd_b), 128'(0));
    @(negedge clk);
    chk("a_lat_edge2", 128'(dvd_a), 128'(1));
    chk("b_lat_edge2", 128'(dvd_b), 128'(1));
    @(negedge clk);
    chk("a_second_slice_vd", 128'(dvd_a), 128'(1));
    @(negedge clk);
    chk("a_drained_vd", 128'(dvd_a), 128'(0));
    chk("b_drained_vd", 128'(dvd_b), 128'(0));

    // Backpressure: six offers, five accepted, sixth overflows.
    drdy_a = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      vd_a = 1; din_a = w3[i];
      if (i < 5) begin
        qa.push_back(w3[i][31:0]); qa.push_back(w3[i][63:32]);
      end
    end
    step();
    vd_a = 0;
    @(negedge clk);
    chk("bp_level", 128'(lvl_a), 128'(4));
    chk("bp_din_rdy", 128'(rdy_a), 128'(0));
    chk("bp_ovf", 128'(ovf_a), 128'(1));
    chk("bp_dout_vd", 128'(dvd_a), 128'(1));
    chk("bp_hold_data", 128'(dout_a), 128'(32'h0000_0100));
    step();
    drdy_a = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_nogap", 128'(dvd_a), 128'(1));
    end
    @(negedge clk);
    chk("bp_end_vd", 128'(dvd_a), 128'(0));
    chk("bp_end_level", 128'(lvl_a), 128'(0));

    // Push every second clock with the sink always ready.
    for (int c = 0; c <= 18; c++) begin
      step();
      if ((c % 2) == 0 && c < 16) begin
        vd_a = 1;
        din_a = {32'hC000_0000 + 32'(c), 32'hD000_0000 + 32'(c)};
        qa.push_back(32'hD000_0000 + 32'(c)); qa.push_back(32'hC000_0000 + 32'(c));
      end else vd_a = 0;
      @(negedge clk);
      chk("rate_level_le1", 128'(lvl_a <= 3'd1), 128'(1));
      if (c >= 2 && c <= 17) chk("rate_continuous", 128'(dvd_a), 128'(1));
      else if (c == 18) chk("rate_end_vd", 128'(dvd_a), 128'(0));
    end

    // Reset with three words buffered and slice 1 of the output word pending.
    drdy_a = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vd_a = 1; din_a = t5[i];
      if (i == 0) qa.push_back(t5[0][31:0]);
    end
    step();
    vd_a = 0;
    @(negedge clk);
    chk("mr_pre_level", 128'(lvl_a), 128'(3));
    chk("mr_pre_vd", 128'(dvd_a), 128'(1));
    step();
    drdy_a = 1;
    step();
    drdy_a = 0; rst_a = 0;
    step();
    rst_a = 1;
    @(negedge clk);
    chk("mr_vd", 128'(dvd_a), 128'(0));
    chk("mr_level", 128'(lvl_a), 128'(0));
    chk("mr_ovf", 128'(ovf_a), 128'(0));
    chk("mr_din_rdy", 128'(rdy_a), 128'(1));
    drdy_a = 1;
    repeat (4) begin
      @(negedge clk);
      chk("mr_silent", 128'(dvd_a), 128'(0));
    end
    step();
    vd_a = 1; din_a = 64'hDEAD_BEEF_0123_4567;
    qa.push_back(32'h0123_4567); qa.push_back(32'hDEAD_BEEF);
    step();
    vd_a = 0;
    repeat (5) @(negedge clk);

    // 128->32 with random stalls on both sides.
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      step();
      cyc++;
      vd_c   = ($urandom_range(0, 3) != 0);
      din_c  = {$urandom(), $urandom(), $urandom(), $urandom()};
      drdy_c = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (vd_c && rdy_c) begin
        for (int s = 0; s < 4; s++) qc.push_back(din_c[s*32 +: 32]);
        sent++;
      end
    end
    chk("c_words_sent", 128'(sent), 128'(1000));
    step();
    vd_c = 0; drdy_c = 1;
    for (int k = 0; k < 200 && qc.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);

    chk("a_queue_empty", 128'(qa.size()), 128'(0));
    chk("b_queue_empty", 128'(qb.size()), 128'(0));
    chk("c_queue_empty", 128'(qc.size()), 128'(0));
    chk("c_final_vd", 128'(dvd_c), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_format_gearbox.md
DATA_FORMAT_GEARBOX -- requirements
Module: data_format_gearbox

Interface
REQ-001 SHALL have parameter DI_WIDTH, default 64: input word width in bits.
REQ-002 SHALL have parameter DO_WIDTH, default 32: output slice width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: input-word buffer depth, power of two, at least 2.
REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 emits the least-significant slice first; 1 emits the most-significant slice first.
REQ-005 SHALL have port clk  input  1  sole clock; all logic samples on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port data_in  input  DI_WIDTH  input word.
REQ-008 SHALL have port din_vd  input  1  input word valid.
REQ-009 SHALL have port din_rdy  output  1  block can accept an input word this cycle.
REQ-010 SHALL have port data_out  output  DO_WIDTH  current output slice.
REQ-011 SHALL have port dout_vd  output  1  data_out valid.
REQ-012 SHALL have port dout_rdy  input  1  downstream accepts the slice.
REQ-013 SHALL have port level  output  CW  number of input words buffered, excluding the word in the output stage; CW = clog2(DEPTH+1).
REQ-014 SHALL have port ovf_err  output  1  sticky flag: an input word was offered while the block was not ready.

Function
REQ-015 SHALL define RATIO = DI_WIDTH/DO_WIDTH; elaboration SHALL fail unless DI_WIDTH is a nonzero integer multiple of DO_WIDTH.
REQ-016 SHALL accept an input word on a rising edge where din_vd=1 and din_rdy=1.
REQ-017 SHALL drive din_rdy = (level < DEPTH), decoded from registered state only; an output pop in the same cycle SHALL NOT raise din_rdy when level = DEPTH.
REQ-018 SHALL write an accepted word into the buffer in FIFO order.
REQ-019 SHALL use an output stage of one DI_WIDTH word register, a slice index 0..RATIO-1 and a loaded flag; dout_vd SHALL equal the loaded flag.
REQ-020 SHALL transfer a slice on a rising edge where dout_vd=1 and dout_rdy=1.
REQ-021 SHALL select data_out as slice k = bits [k*DO_WIDTH +: DO_WIDTH] when MSB_FIRST=0, and slice RATIO-1-k when MSB_FIRST=1, where k is the slice index.
REQ-022 SHALL hold data_out and dout_vd stable while dout_vd=1 and dout_rdy=0.
REQ-023 SHALL increment the slice index on each transfer of a slice with index below RATIO-1.
REQ-024 SHALL handle a transfer of slice RATIO-1 as follows: if the buffer is non-empty, pop the head into the output stage in the same edge and reset the index to 0, giving no bubble; otherwise clear the loaded flag.
REQ-025 SHALL load the buffer head into an unloaded output stage on the next edge.
REQ-026 SHALL give latency into an idle block of 2 edges: word accepted at edge N gives dout_vd=1 after edge N+1.
REQ-027 SHALL sustain throughput of one slice per clock with dout_rdy held at 1, and SHALL accept one input word per RATIO clocks without backpressure.
REQ-028 SHALL, on a simultaneous push and pop, leave level unchanged and keep order intact.
REQ-029 SHALL wrap the buffer pointers modulo DEPTH.
REQ-030 SHALL set ovf_err on an edge where din_vd=1 and din_rdy=0; the offered word is not written, and the flag SHALL clear only on reset.
REQ-031 SHALL, when RATIO = 1, pass words through unchanged with the same handshake.

Reset
REQ-032 SHALL, on a rising edge with reset_n=0, clear all of the following: buffer pointers, level, loaded flag, slice index, dout_vd, data_out, ovf_err; din_rdy SHALL be 1 after that edge.
REQ-033 SHALL discard buffered and partially emitted words on reset mid-operation, with no slice emitted after the reset edge until new input arrives.
REQ-034 SHALL NOT reset the buffer storage array.

Structure
REQ-035 SHALL place RATIO, CW and the slice-select helper function in shared package data_format_pkg.
REQ-036 SHALL implement the buffer as sub-module data_fifo_sync: single clock, synchronous active-low reset, first-word-fall-through head, with count output.
REQ-037 SHALL implement the output stage and slice sequencing in the top module.

Verification
REQ-038 Bench SHALL cover: defaults, MSB_FIRST=0, dout_rdy=1, push 0x1111_2222_3333_4444 -> after 2 edges, data_out 0x3333_4444 then 0x1111_2222 on consecutive cycles, then dout_vd=0.
REQ-039 Bench SHALL cover: MSB_FIRST=1, same word -> 0x1111_2222 then 0x3333_4444.
REQ-040 Bench SHALL cover: dout_rdy=0, push 6 words back-to-back -> 5 accepted (4 buffered, 1 in output stage), din_rdy=0, level=4, ovf_err=1 after the sixth offer; release dout_rdy -> 10 slices in order, no gaps.
REQ-041 Bench SHALL cover: continuous push every 2 clocks with dout_rdy=1 -> dout_vd stays 1 continuously after first output, level never exceeds 1.
REQ-042 Bench SHALL cover: reset_n low for one edge while level=3 and slice 1 pending -> dout_vd=0, level=0, ovf_err=0, din_rdy=1 next cycle; then a fresh word emits correctly.
REQ-043 Bench SHALL cover: DI_WIDTH=128, DO_WIDTH=32, random stall on both sides over 1000 words -> reference-model scoreboard matches every slice.
